// File: rtl/timer_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_scheduler                                              |
// | Description : Four-channel deadline timer driven by one free-running       |
// |               counter. Each channel is one-shot or periodic; a single      |
// |               comparator is shared round-robin across the channels.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          in   1      system clock, rising edge                       |
// |   rst_n        in   1      synchronous active-low reset                    |
// |   req          in   1      configuration request, held until ack           |
// |   req_ch       in   2      target channel                                  |
// |   req_limit    in   WIDTH  delay in cycles (MSB ignored), 0 = cancel       |
// |   req_periodic in   1      1 = auto-reload, 0 = one-shot                   |
// |   ack          out  1      one-cycle accept pulse                          |
// |   int_clr      in   4      per-channel interrupt clear                     |
// |   int_o        out  4      per-channel sticky interrupt                    |
// |   armed_o      out  4      per-channel ARMED status                        |
// |   count_o      out  WIDTH  free-running count                              |
// +----------------------------------------------------------------------------+
module timer_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       req_ch,
  input  logic [WIDTH-1:0] req_limit,
  input  logic             req_periodic,
  output logic             ack,
  input  logic [3:0]       int_clr,
  output logic [3:0]       int_o,
  output logic [3:0]       armed_o,
  output logic [WIDTH-1:0] count_o
);

  // Channel count is tied to the 2-bit channel select and 4-bit vectors.
  localparam int NCH = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ARMED = 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       scan_q, scan_d;
  logic             ack_q, ack_d;
  logic [NCH-1:0]   int_q, int_d;
  logic             state_q    [NCH];
  logic             state_d    [NCH];
  logic [WIDTH-1:0] deadline_q [NCH];
  logic [WIDTH-1:0] deadline_d [NCH];
  logic [WIDTH-2:0] limit_q    [NCH];
  logic [WIDTH-2:0] limit_d    [NCH];
  logic             periodic_q [NCH];
  logic             periodic_d [NCH];

  logic             w_sample;
  logic [WIDTH-2:0] w_lim;
  logic             w_unused_limit_msb;
  logic [WIDTH-1:0] w_diff;
  logic             w_cfg_on_scan;
  logic             w_expire;

  // A new request is only taken while no ack is outstanding, so a requester
  // that keeps req up through the ack cycle is accepted exactly once.
  assign w_sample           = req & ~ack_q;
  assign w_lim              = req_limit[WIDTH-2:0];
  assign w_unused_limit_msb = req_limit[WIDTH-1];

  // Wrap-aware "count has reached deadline": the difference is treated as a
  // signed value, valid because limits are kept below half the count range.
  assign w_diff        = count_q - deadline_q[scan_q];
  assign w_cfg_on_scan = w_sample && (req_ch == scan_q);
  assign w_expire      = (state_q[scan_q] == ST_ARMED) && !w_diff[WIDTH-1]
                         && !w_cfg_on_scan;

  always_comb begin
    count_d    = count_q + WIDTH'(1);
    scan_d     = scan_q + 2'd1;
    ack_d      = w_sample;
    int_d      = int_q & ~int_clr;
    state_d    = state_q;
    deadline_d = deadline_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;

    // Expiry is applied after the clear so that a simultaneous set wins.
    if (w_expire) begin
      int_d[scan_q] = 1'b1;
      if (periodic_q[scan_q]) begin
        // Reload from the old deadline, not the current count: no drift.
        deadline_d[scan_q] = deadline_q[scan_q] + {1'b0, limit_q[scan_q]};
      end else begin
        state_d[scan_q] = ST_IDLE;
      end
    end

    if (w_sample) begin
      if (w_lim != '0) begin
        deadline_d[req_ch] = count_q + {1'b0, w_lim};
        limit_d[req_ch]    = w_lim;
        periodic_d[req_ch] = req_periodic;
        state_d[req_ch]    = ST_ARMED;
        int_d[req_ch]      = 1'b0;
      end else begin
        state_d[req_ch] = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      scan_q  <= '0;
      ack_q   <= 1'b0;
      int_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]    <= ST_IDLE;
        deadline_q[i] <= '0;
        limit_q[i]    <= '0;
        periodic_q[i] <= 1'b0;
      end
    end else begin
      count_q    <= count_d;
      scan_q     <= scan_d;
      ack_q      <= ack_d;
      int_q      <= int_d;
      state_q    <= state_d;
      deadline_q <= deadline_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_status
    assign armed_o[gi] = (state_q[gi] == ST_ARMED);
  end

  assign ack     = ack_q;
  assign int_o   = int_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_timer_scheduler                                           |
// | Description : Self-checking bench for timer_scheduler. Directed scenarios  |
// |               use hand-derived expectations; the random phase compares     |
// |               every cycle with a cycle-level arithmetic reference model.   |
// |               A narrow count width keeps wrap-around reachable quickly.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_timer_scheduler;

  localparam int W    = 10;
  localparam int M    = 1 << W;
  localparam int HALF = M / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [1:0]   req_ch;
  logic [W-1:0] req_limit;
  logic         req_periodic;
  logic         ack;
  logic [3:0]   int_clr;
  logic [3:0]   int_o;
  logic [3:0]   armed_o;
  logic [W-1:0] count_o;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state (plain integers, modulo arithmetic).
  int       m_count;
  logic     m_ack;
  logic [3:0] m_int, m_armed, m_per;
  int       m_dl  [4];
  int       m_lim [4];

  always #5 clk = ~clk;

  timer_scheduler #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_ch       (req_ch),
    .req_limit    (req_limit),
    .req_periodic (req_periodic),
    .ack          (ack),
    .int_clr      (int_clr),
    .int_o        (int_o),
    .armed_o      (armed_o),
    .count_o      (count_o)
  );

  // Advance one clock; the model computes its next state from the inputs
  // that are about to be sampled, then commits after the edge.
  task automatic tick();
    int         cnt, sch, lim;
    logic       a, smp, ex;
    logic [3:0] it, ar, pe;
    int         dl [4];
    int         lm [4];
    cnt = m_count; a = m_ack; it = m_int; ar = m_armed; pe = m_per;
    dl = m_dl; lm = m_lim;
    if (!rst_n) begin
      cnt = 0; a = 1'b0; it = '0; ar = '0; pe = '0;
      for (int i = 0; i < 4; i++) begin dl[i] = 0; lm[i] = 0; end
    end else begin
      smp = req && !m_ack;
      a   = smp;
      sch = m_count % 4;
      ex  = m_armed[sch] && ((((m_count - m_dl[sch]) % M) + M) % M < HALF)
            && !(smp && (int'(req_ch) == sch));
      it  = m_int & ~int_clr;
      if (ex) begin
        it[sch] = 1'b1;
        if (m_per[sch]) dl[sch] = (m_dl[sch] + m_lim[sch]) % M;
        else            ar[sch] = 1'b0;
      end
      lim = int'(req_limit) % HALF;
      if (smp) begin
        if (lim != 0) begin
          dl[req_ch] = (m_count + lim) % M;
          lm[req_ch] = lim;
          pe[req_ch] = req_periodic;
          ar[req_ch] = 1'b1;
          it[req_ch] = 1'b0;
        end else begin
          ar[req_ch] = 1'b0;
        end
      end
      cnt = (m_count + 1) % M;
    end
    @(posedge clk);
    #1;
    m_count = cnt; m_ack = a; m_int = it; m_armed = ar; m_per = pe;
    m_dl = dl; m_lim = lm;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req = 1'b0; req_ch = '0; req_limit = '0;
    req_periodic = 1'b0; int_clr = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Tick until count_o equals target, bounded by one full wrap.
  task automatic run_to(input int target);
    int n = 0;
    while (int'(count_o) != target && n < M + 8) begin tick(); n++; end
    if (int'(count_o) != target) begin
      n_vec++; n_fail++;
      $display("FAIL run_to: count=%0d expected %0d", count_o, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; req_ch = 2'd1; req_limit = W'(7);
    req_periodic = 1'b0; int_clr = 4'hf;
    tick(); tick();
    n_vec++;
    if ({count_o, ack, int_o, armed_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d ack=%b int=%b armed=%b expected all 0",
               count_o, ack, int_o, armed_o);
    end
    req = 1'b0; int_clr = '0; rst_n = 1'b1;
  endtask

  task automatic test_oneshot();
    int n = 0;
    reset_dut();
    run_to(5);
    req = 1'b1; req_ch = 2'd0; req_limit = W'(10); req_periodic = 1'b0;
    tick();
    n_vec++;
    if (ack !== 1'b1 || count_o !== W'(6) || armed_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_ack: ack=%b count=%0d armed=%b expected ack=1 count=6 armed[0]=1",
               ack, count_o, armed_o);
    end
    req = 1'b0;
    tick();
    n_vec++;
    if (ack !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_ack_pulse: ack=%b expected 0", ack);
    end
    while (int_o[0] !== 1'b1 && n < 40) begin tick(); n++; end
    // Deadline 15; channel 0 is scanned at count 16, flag visible at 17.
    n_vec++;
    if (int_o[0] !== 1'b1 || count_o !== W'(17)) begin
      n_fail++;
      $display("FAIL oneshot_rise: int=%b count=%0d expected int[0]=1 at count 17",
               int_o, count_o);
    end
    n_vec++;
    if (armed_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_disarm: armed=%b expected armed[0]=0", armed_o);
    end
    int_clr = 4'b0001; tick(); int_clr = '0;
    n_vec++;
    if (int_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_clear: int=%b expected int[0]=0", int_o);
    end
  endtask

  task automatic test_periodic();
    reset_dut();
    req = 1'b1; req_ch = 2'd2; req_limit = W'(8); req_periodic = 1'b1;
    tick();
    req = 1'b0;
    n_vec++;
    if (ack !== 1'b1 || armed_o[2] !== 1'b1) begin
      n_fail++; $display("FAIL periodic_arm: ack=%b armed=%b expected ack=1 armed[2]=1", ack, armed_o);
    end
    // Deadline 8k; channel 2 is scanned at 8k+2, flag visible at 8k+3.
    for (int k = 1; k <= 100; k++) begin
      int n = 0;
      while (int_o[2] !== 1'b1 && n < 20) begin tick(); n++; end
      n_vec++;
      if (int_o[2] !== 1'b1 || int'(count_o) != (8 * k + 3) % M) begin
        n_fail++;
        $display("FAIL periodic_rise_%0d: int=%b count=%0d expected int[2]=1 at count %0d",
                 k, int_o, count_o, (8 * k + 3) % M);
      end
      int_clr = 4'b0100; tick(); int_clr = '0;
      if (k == 1) begin
        n_vec++;
        if (int_o[2] !== 1'b0 || armed_o[2] !== 1'b1) begin
          n_fail++;
          $display("FAIL periodic_clear: int=%b armed=%b expected int[2]=0 armed[2]=1", int_o, armed_o);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    reset_dut();
    run_to(M - 4);
    req = 1'b1; req_ch = 2'd1; req_limit = W'(6); req_periodic = 1'b0;
    tick();
    req = 1'b0;
    // Deadline wraps to 2; channel 1 is scanned at 1021 and 1 (both before
    // the deadline) and then at 5, so the flag appears at count 6.
    while (int_o[1] !== 1'b1 && n < 30) begin tick(); n++; end
    n_vec++;
    if (int_o[1] !== 1'b1 || count_o !== W'(6)) begin
      n_fail++;
      $display("FAIL wrap_rise: int=%b count=%0d expected int[1]=1 at count 6", int_o, count_o);
    end
  endtask

  task automatic test_limit_msb();
    int n = 0;
    reset_dut();
    run_to(8);
    req = 1'b1; req_ch = 2'd3; req_limit = W'(HALF + 5); req_periodic = 1'b0;
    tick();
    req = 1'b0;
    // Effective limit 5 gives deadline 13; channel 3 scanned at 15.
    while (int_o[3] !== 1'b1 && n < 40) begin tick(); n++; end
    n_vec++;
    if (int_o[3] !== 1'b1 || count_o !== W'(16)) begin
      n_fail++;
      $display("FAIL limit_msb: int=%b count=%0d expected int[3]=1 at count 16", int_o, count_o);
    end
  endtask

  task automatic test_cancel();
    logic seen = 1'b0;
    reset_dut();
    run_to(3);
    req = 1'b1; req_ch = 2'd3; req_limit = W'(50); req_periodic = 1'b0;
    tick();
    req = 1'b0;
    run_to(13);
    req = 1'b1; req_ch = 2'd3; req_limit = '0;
    tick();
    req = 1'b0;
    n_vec++;
    if (ack !== 1'b1 || armed_o[3] !== 1'b0) begin
      n_fail++; $display("FAIL cancel_disarm: ack=%b armed=%b expected ack=1 armed[3]=0", ack, armed_o);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (int_o[3] !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL cancel_no_int: int[3] was set=%b expected 0", seen);
    end
  endtask

  task automatic test_collisions();
    int n = 0;
    reset_dut();
    run_to(4);
    req = 1'b1; req_ch = 2'd1; req_limit = W'(5); req_periodic = 1'b0;
    tick();
    req = 1'b0;
    run_to(9);
    int_clr = 4'b0010;          // clear on the exact expiry cycle
    tick();
    n_vec++;
    if (int_o[1] !== 1'b1) begin
      n_fail++; $display("FAIL clr_vs_set: int=%b expected int[1]=1", int_o);
    end
    tick();                     // int_clr still high: now it must clear
    int_clr = '0;
    n_vec++;
    if (int_o[1] !== 1'b0) begin
      n_fail++; $display("FAIL clr_after: int=%b expected int[1]=0", int_o);
    end
    run_to(12);
    req = 1'b1; req_ch = 2'd0; req_limit = W'(4); req_periodic = 1'b0;
    tick();
    req = 1'b0;
    run_to(16);                 // ch0 deadline and scan slot coincide here
    req = 1'b1; req_ch = 2'd0; req_limit = W'(20); req_periodic = 1'b0;
    tick();
    req = 1'b0;
    n_vec++;
    if (ack !== 1'b1 || int_o[0] !== 1'b0 || armed_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_vs_expiry: ack=%b int=%b armed=%b expected ack=1 int[0]=0 armed[0]=1",
               ack, int_o, armed_o);
    end
    while (int_o[0] !== 1'b1 && n < 40) begin tick(); n++; end
    n_vec++;
    if (int_o[0] !== 1'b1 || count_o !== W'(37)) begin
      n_fail++;
      $display("FAIL cfg_new_deadline: int=%b count=%0d expected int[0]=1 at count 37", int_o, count_o);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    tick();
    req = 1'b1; req_ch = 2'd2; req_limit = '0; req_periodic = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack === 1'b1) acks++;
      if (i == 1) req = 1'b0;   // requester drops after the ack cycle
    end
    n_vec++;
    if (acks != 1) begin
      n_fail++; $display("FAIL held_req_acks: acks=%0d expected 1", acks);
    end
  endtask

  task automatic test_reset_inflight();
    logic bad = 1'b0;
    reset_dut();
    req = 1'b1; req_ch = 2'd0; req_limit = W'(3); req_periodic = 1'b0; tick();
    req = 1'b0; tick();
    req = 1'b1; req_ch = 2'd2; req_limit = W'(3); tick();
    req = 1'b0;
    run_to(10);
    req = 1'b1; req_ch = 2'd1; req_limit = W'(200); tick();
    req = 1'b0; tick();
    req = 1'b1; req_ch = 2'd3; req_limit = W'(200); req_periodic = 1'b1; tick();
    req = 1'b0; tick();
    n_vec++;
    if (int_o !== 4'b0101 || armed_o !== 4'b1010) begin
      n_fail++;
      $display("FAIL pre_reset_state: int=%b armed=%b expected int=0101 armed=1010", int_o, armed_o);
    end
    rst_n = 1'b0; req = 1'b1; req_ch = 2'd1; req_limit = '0; req_periodic = 1'b0;
    tick();
    n_vec++;
    if ({count_o, ack, int_o, armed_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_override: count=%0d ack=%b int=%b armed=%b expected all 0",
               count_o, ack, int_o, armed_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (ack !== 1'b1 || count_o !== W'(1) || armed_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL req_after_reset: ack=%b count=%0d armed=%b expected ack=1 count=1 armed=0000",
               ack, count_o, armed_o);
    end
    req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (int_o !== 4'b0000 || armed_o !== 4'b0000) bad = 1'b1;
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_quiet: activity seen=%b expected 0", bad);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    reset_dut();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!req && $urandom_range(0, 3) == 0) begin
        int r = $urandom_range(0, 9);
        req          = 1'b1;
        req_ch       = 2'($urandom);
        req_periodic = 1'($urandom);
        if (r == 0)      req_limit = '0;
        else if (r == 1) req_limit = W'(HALF + $urandom_range(0, 3));
        else if (r == 2) req_limit = W'($urandom_range(HALF - 8, HALF - 1));
        else             req_limit = W'($urandom_range(1, 40));
      end
      int_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rst_n   = ($urandom_range(0, 599) != 0);
      tick();
      n_vec++;
      if ({count_o, ack, int_o, armed_o} !== {W'(m_count), m_ack, m_int, m_armed}) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle_%0d: count=%0d ack=%b int=%b armed=%b expected count=%0d ack=%b int=%b armed=%b",
                   cyc, count_o, ack, int_o, armed_o, m_count, m_ack, m_int, m_armed);
        end
      end
      if (req && ack && $urandom_range(0, 7) != 0) req = 1'b0;
    end
    rst_n = 1'b1; req = 1'b0; int_clr = '0;
  endtask

  initial begin
    m_count = 0; m_ack = 1'b0; m_int = '0; m_armed = '0; m_per = '0;
    for (int i = 0; i < 4; i++) begin m_dl[i] = 0; m_lim[i] = 0; end
    rst_n = 1'b0; req = 1'b0; req_ch = '0; req_limit = '0;
    req_periodic = 1'b0; int_clr = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_limit_msb();
    test_cancel();
    test_collisions();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, width of the free-running count, limits and deadlines.
REQ-002 Parameter NCH, fixed at 4, number of timer channels; not overridable.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 req  in  1  configuration request; held high until ack seen.
REQ-006 req_ch  in  2  target channel of the request.
REQ-007 req_limit  in  WIDTH  delay in clk cycles; 0 means cancel.
REQ-008 req_periodic  in  1  1 = auto-reload after each expiry, 0 = one-shot.
REQ-009 ack  out  1  one-cycle pulse: request accepted.
REQ-010 int_clr  in  4  per-channel interrupt clear, one bit per channel.
REQ-011 int_o  out  4  per-channel sticky interrupt flag.
REQ-012 armed_o  out  4  per-channel status, 1 = channel ARMED.
REQ-013 count_o  out  WIDTH  current free-running count.

Function
REQ-014 count SHALL increment by 1 every cycle and wrap from 2^WIDTH-1 to 0.
REQ-015 Each channel SHALL hold state IDLE or ARMED, a WIDTH-bit deadline, a 31-bit limit and a periodic bit.
REQ-016 Bit WIDTH-1 of req_limit SHALL be ignored; effective limit = req_limit[WIDTH-2:0].
REQ-017 Request is sampled when req=1 and ack=0; ack SHALL pulse high on the following cycle; a request sampled while ack=1 SHALL be ignored.
REQ-018 On sampling with effective limit != 0: deadline <= count (at sample cycle) + limit mod 2^WIDTH; limit and periodic bit stored; state <= ARMED; int_o[req_ch] <= 0.
REQ-019 On sampling with effective limit == 0: state of req_ch <= IDLE; int_o[req_ch] unchanged.
REQ-020 A single shared comparator SHALL be time-multiplexed by a 2-bit scan pointer advancing 0,1,2,3,0,... one step per cycle.
REQ-021 Channel at scan pointer expires when ARMED and bit WIDTH-1 of (count - deadline) == 0 (wrap-aware, valid for limits < 2^(WIDTH-1)).
REQ-022 On expiry: int_o[ch] <= 1 next cycle; one-shot -> IDLE; periodic -> deadline <= deadline + limit, stays ARMED.
REQ-023 Expiry detection latency SHALL be 0 to 3 cycles after count reaches deadline; periodic reloads from the old deadline so no drift accumulates.
REQ-024 Configuration sampled for the channel under scan in the same cycle SHALL take precedence; that expiry is discarded.
REQ-025 int_clr[i] SHALL clear int_o[i]; expiry set and int_clr on the same channel in the same cycle -> set wins.
REQ-026 int_o SHALL remain 1 until cleared or reconfigured; repeated expiries while set SHALL not queue.
REQ-027 armed_o[i] SHALL equal 1 exactly when channel i is ARMED.

Reset
REQ-028 With rst_n=0 at a clock edge: count, scan pointer, ack, int_o, armed_o <= 0; all channels IDLE; deadlines and limits <= 0.
REQ-029 Reset SHALL override any in-flight request or expiry in the same cycle; req held through reset is sampled only once rst_n=1 and ack=0.

Verification
REQ-030 Reset, then req ch0 limit=10 one-shot sampled at count=5 -> ack at count=6, int_o[0] rises within count 15..18, armed_o[0]=0 afterwards.
REQ-031 Periodic ch2 limit=8 sampled at count=0 -> deadlines 8,16,24; after each int_clr[2], int_o[2] reasserts every 8 cycles with no drift over 100 periods.
REQ-032 Wrap: force count near 2^32-4, arm ch1 limit=6 -> int_o[1] sets after count wraps to 2..5, not before wrap.
REQ-033 Cancel: arm ch3 limit=50, then req ch3 limit=0 at +10 -> armed_o[3]=0, int_o[3] never set.
REQ-034 Collisions: int_clr[1] on expiry cycle -> int_o[1]=1; reconfigure ch0 on its scan cycle at expiry -> no int, new deadline used; req held 3 cycles -> exactly one ack.
REQ-035 Assert rst_n=0 with two channels armed and int_o=4'b0101 -> all outputs 0 next cycle, no interrupt after release.
